// File: rtl/s3g_tx.sv
// s3g_tx: builds a framed packet from buffered payload bytes and feeds it one
// byte at a time to a byte UART. Frame: 0xD5, LEN, payload, CRC-8 (Maxim).
module s3g_tx #(
  parameter int MAX_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       send,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err_overflow
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CRC     = 3'd4,
    S_GUARD   = 3'd5,
    S_FIN     = 3'd6
  } state_t;

  localparam logic [7:0] MAX_CNT  = 8'(MAX_LEN);
  localparam logic [7:0] SYNC_BYTE = 8'hD5;

  // Maxim/iButton CRC-8 step over one byte, LSB first, reflected poly 0x8C.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc_in,
                                             input logic [7:0] data_in);
    logic [7:0] c;
    logic [7:0] d;
    logic       mix;
    c = crc_in;
    d = data_in;
    for (int b = 0; b < 8; b++) begin
      mix = c[0] ^ d[0];
      c   = {1'b0, c[7:1]};
      if (mix) begin
        c = c ^ 8'h8C;
      end else begin
        c = c;
      end
      d = {1'b0, d[7:1]};
    end
    return c;
  endfunction

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] buf_q [MAX_LEN];
  logic [7:0] buf_d [MAX_LEN];
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] pay_byte_s;
  logic       wr_ok_s;

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_overflow = err_q;

  // Select the payload byte at the current read index.
  always_comb begin
    pay_byte_s = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx_q == 8'(i)) begin
        pay_byte_s = buf_q[i];
      end else begin
        pay_byte_s = pay_byte_s;
      end
    end
  end

  // Buffer write: only in IDLE and only while there is room.
  always_comb begin
    wr_ok_s = (state_q == S_IDLE) && wr_en && (cnt_q < MAX_CNT);
    for (int i = 0; i < MAX_LEN; i++) begin
      if (wr_ok_s && (cnt_q == 8'(i))) begin
        buf_d[i] = wr_data;
      end else begin
        buf_d[i] = buf_q[i];
      end
    end
  end

  // Next-state and output logic for the framing sequencer.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    crc_d      = crc_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          if (cnt_q < MAX_CNT) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q;
        end
        // Send wins over a simultaneous overflow: the flag is cleared.
        if (send) begin
          state_d = S_START;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (!tx_busy) begin
          tx_data_d  = SYNC_BYTE;
          tx_start_d = 1'b1;
          ret_d      = S_LEN;
          state_d    = S_GUARD;
        end else begin
          state_d = S_START;
        end
      end
      S_LEN: begin
        if (!tx_busy) begin
          tx_data_d  = cnt_q;
          tx_start_d = 1'b1;
          idx_d      = 8'd0;
          ret_d      = (cnt_q == 8'd0) ? S_CRC : S_PAYLOAD;
          state_d    = S_GUARD;
        end else begin
          state_d = S_LEN;
        end
      end
      S_PAYLOAD: begin
        if (!tx_busy) begin
          tx_data_d  = pay_byte_s;
          tx_start_d = 1'b1;
          crc_d      = crc8_update(crc_q, pay_byte_s);
          idx_d      = idx_q + 8'd1;
          ret_d      = ((idx_q + 8'd1) == cnt_q) ? S_CRC : S_PAYLOAD;
          state_d    = S_GUARD;
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_CRC: begin
        if (!tx_busy) begin
          tx_data_d  = crc_q;
          tx_start_d = 1'b1;
          ret_d      = S_FIN;
          state_d    = S_GUARD;
        end else begin
          state_d = S_CRC;
        end
      end
      // The UART cannot report busy yet in the cycle it loads, so skip it.
      S_GUARD: begin
        state_d = ret_q;
      end
      S_FIN: begin
        if (!tx_busy) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = 8'd0;
          crc_d   = 8'd0;
          idx_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          state_d = S_FIN;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= 8'd0;
      crc_q      <= 8'd0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      crc_q      <= crc_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Payload storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < MAX_LEN; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_s3g_tx.sv
// Self-checking bench for s3g_tx: random payloads, UART busy model, frame
// reference model built from the frame format and CRC-8 definition.
module tb_s3g_tx;
  localparam int MAX_LEN = 32;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       send;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       err_overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int send_cyc;
  int uart_n = 0;
  int busy_left = 0;
  int done_cnt = 0;
  logic [7:0] cap[$];
  int         cap_cyc[$];

  s3g_tx #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .send(send),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .busy(busy),
    .done(done), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // UART model and frame monitor, evaluated on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      busy_left = 0;
      tx_busy   = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (tx_start) begin
        cap.push_back(tx_data);
        cap_cyc.push_back(cyc);
        busy_left = uart_n;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      tx_busy = (busy_left > 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC-8 Maxim as division of the LSB-first bit stream of the payload.
  function automatic logic [7:0] model_crc(input bq_t pl);
    logic [7:0] r;
    bit         bits[$];
    bit         fb;
    r = 8'h00;
    foreach (pl[k]) for (int j = 0; j < 8; j++) bits.push_back(pl[k][j]);
    foreach (bits[k]) begin
      fb = r[0] ^ bits[k];
      r  = r >> 1;
      if (fb) r = r ^ 8'h8C;
    end
    return r;
  endfunction

  function automatic bq_t model_frame(input bq_t pl);
    bq_t f;
    f.push_back(8'hD5);
    f.push_back(8'(pl.size()));
    foreach (pl[k]) f.push_back(pl[k]);
    f.push_back(model_crc(pl));
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_all(input bq_t pl);
    foreach (pl[k]) begin
      wr_data = pl[k];
      wr_en   = 1'b1;
      tick();
      wr_en   = 1'b0;
    end
  endtask

  function automatic bq_t rand_payload(input int n);
    bq_t p;
    for (int k = 0; k < n; k++) p.push_back(8'($urandom_range(0, 255)));
    return p;
  endfunction

  // Send, optionally poke wr_en/send mid-frame, wait for done, compare frame.
  task automatic send_and_check(input string tag, input bq_t pl, input int n_uart,
                                input bit inject);
    bq_t exp;
    int  waited;
    exp = model_frame(pl);
    cap.delete();
    cap_cyc.delete();
    done_cnt = 0;
    uart_n   = n_uart;
    send     = 1'b1;
    send_cyc = cyc;
    tick();
    send     = 1'b0;
    waited   = 0;
    while (done_cnt == 0 && waited < 4000) begin
      if (inject && waited == 5) begin
        wr_data = 8'hAA;
        wr_en   = 1'b1;
        send    = 1'b1;
        tick();
        wr_en   = 1'b0;
        send    = 1'b0;
      end else begin
        tick();
      end
      waited++;
    end
    tick();
    tick();
    check({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    check({tag, "_nbytes"}, 32'(cap.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      if (k < cap.size())
        check($sformatf("%s_byte%0d", tag, k), 32'(cap[k]), 32'(exp[k]));
    end
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bq_t p;
    int  snap;
    int  waited;
    rst = 1'b0; wr_data = 8'h00; wr_en = 1'b0; send = 1'b0;
    #12;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_err",      32'(err_overflow), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Three bytes, slow UART; CRC of 01 02 03 is D8.
    p = '{8'h01, 8'h02, 8'h03};
    write_all(p);
    send_and_check("f123", p, 10, 1'b0);
    if (cap.size() == 6) check("f123_crc_const", 32'(cap[5]), 32'hD8);

    // One byte, UART never busy: latency and guard spacing.
    p = '{8'h01};
    write_all(p);
    send_and_check("f01", p, 0, 1'b0);
    if (cap.size() == 4) begin
      check("f01_crc_const", 32'(cap[3]), 32'h5E);
      check("f01_latency", 32'(cap_cyc[0] - send_cyc), 32'd2);
      for (int k = 1; k < 4; k++)
        check($sformatf("f01_gap%0d", k), 32'(cap_cyc[k] - cap_cyc[k-1]), 32'd2);
    end

    // Empty frame.
    p = {};
    send_and_check("fempty", p, 3, 1'b0);

    // Overflow: one byte beyond capacity is dropped.
    p = rand_payload(MAX_LEN + 1);
    write_all(p);
    check("ovf_set", 32'(err_overflow), 32'd1);
    p.pop_back();
    send_and_check("fovf", p, 2, 1'b0);
    check("ovf_cleared", 32'(err_overflow), 32'd0);

    // Writes and send during an active frame are ignored.
    p = rand_payload(2);
    write_all(p);
    send_and_check("factive", p, 4, 1'b1);
    check("active_no_err", 32'(err_overflow), 32'd0);
    p = {};
    send_and_check("factive_next", p, 1, 1'b0);

    // Reset in the middle of the payload.
    p = rand_payload(5);
    write_all(p);
    cap.delete();
    done_cnt = 0;
    uart_n   = 10;
    send     = 1'b1;
    tick();
    send     = 1'b0;
    waited   = 0;
    while (cap.size() < 4 && waited < 2000) begin
      tick();
      waited++;
    end
    check("rstmid_reached_payload", 32'(cap.size() >= 4), 32'd1);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("rstmid_tx_start", 32'(tx_start), 32'd0);
    check("rstmid_busy",     32'(busy),     32'd0);
    check("rstmid_tx_data",  32'(tx_data),  32'h00);
    check("rstmid_done",     32'(done),     32'd0);
    snap = cap.size();
    tick(); tick(); tick();
    rst = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    check("rstmid_no_more_tx", 32'(cap.size()), 32'(snap));
    check("rstmid_no_done",    32'(done_cnt),   32'd0);
    p = rand_payload(3);
    write_all(p);
    send_and_check("fafter_rst", p, 2, 1'b0);

    // Random frames with random UART speed.
    for (int it = 0; it < 8; it++) begin
      p = rand_payload($urandom_range(0, MAX_LEN));
      write_all(p);
      send_and_check($sformatf("frand%0d", it), p, $urandom_range(0, 5), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
